// File: rtl/scanner_result_arbiter.sv
// Votes on per-line EAN-13 decodes and writes each confirmed code once per frame to the result FIFO.
// Optional build macro SCANNER_ARB_CHECKSUM_EN discards decodes that fail the EAN-13 checksum.
module scanner_result_arbiter #(
    parameter int unsigned CONFIRM_COUNT = 4,
    parameter int unsigned MAX_LINE_GAP  = 8,
    parameter int unsigned VPIX_W        = 10,
    parameter int unsigned CODE_W        = 52
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEnable,
    input  logic                     iFrameStart,
    input  logic                     iNewData,
    input  logic [CODE_W-1:0]        iDataCode,
    input  logic [VPIX_W-1:0]        iVpixel,
    input  logic                     iFifoFull,
    output logic                     oFifoWrEn,
    output logic [VPIX_W+CODE_W-1:0] oFifoData,
    output logic                     oBusy,
    output logic [15:0]              oConfirmCount,
    output logic [15:0]              oDropCount,
    output logic [15:0]              oBadCount
);

    localparam logic [3:0]        ConfirmLast = 4'(CONFIRM_COUNT);
    localparam logic [VPIX_W-1:0] MaxGap      = VPIX_W'(MAX_LINE_GAP);
    localparam int unsigned       NumDigits   = CODE_W / 4;

    typedef enum logic [1:0] {StIdle, StTrack, StEmit, StHold} arbState_t;

    arbState_t stateQ, stateD;

    logic              enableQ, frameStartQ, newDataQ, fifoFullQ;
    logic [CODE_W-1:0] codeInQ;
    logic [VPIX_W-1:0] vpixInQ;

    logic [CODE_W-1:0] codeQ, codeD;
    logic [VPIX_W-1:0] firstLineQ, firstLineD;
    logic [VPIX_W-1:0] lastLineQ, lastLineD;
    logic [3:0]        countQ, countD;
    logic [VPIX_W-1:0] lineGap;
    logic              restart, writeD, dropInc;
    logic              checksumOk;

`ifdef SCANNER_ARB_CHECKSUM_EN
    logic [8:0] digitSum;

    // Digit 0 is the leftmost digit and carries weight 1.
    always_comb begin
        digitSum = '0;
        for (int i = 0; i < NumDigits; i++) begin
            if (i % 2 == 0) begin
                digitSum = digitSum + 9'(iDataCode[4*i +: 4]);
            end else begin
                digitSum = digitSum + 9'(iDataCode[4*i +: 4]) * 9'd3;
            end
        end
        checksumOk = (digitSum % 9'd10) == 9'd0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oBadCount <= '0;
        end else if (iNewData && iEnable && !checksumOk && oBadCount != 16'hFFFF) begin
            oBadCount <= oBadCount + 16'd1;
        end
    end
`else
    assign checksumOk = 1'b1;
    assign oBadCount  = '0;
`endif

    // Input register stage; rejected decodes never reach the FSM.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            enableQ     <= 1'b0;
            frameStartQ <= 1'b0;
            newDataQ    <= 1'b0;
            fifoFullQ   <= 1'b0;
            codeInQ     <= '0;
            vpixInQ     <= '0;
        end else begin
            enableQ     <= iEnable;
            frameStartQ <= iFrameStart;
            newDataQ    <= iNewData & iEnable & checksumOk;
            fifoFullQ   <= iFifoFull;
            codeInQ     <= iDataCode;
            vpixInQ     <= iVpixel;
        end
    end

    assign lineGap = vpixInQ - lastLineQ;

    always_comb begin
        stateD     = stateQ;
        codeD      = codeQ;
        firstLineD = firstLineQ;
        lastLineD  = lastLineQ;
        countD     = countQ;
        restart    = 1'b0;
        writeD     = 1'b0;
        dropInc    = 1'b0;

        if (!enableQ) begin
            stateD = StIdle;
        end else if (frameStartQ) begin
            dropInc = (stateQ == StEmit);
            stateD  = StIdle;
            restart = newDataQ;
        end else begin
            unique case (stateQ)
                StIdle: restart = newDataQ;
                StTrack: begin
                    if (newDataQ) begin
                        if (codeInQ == codeQ && lineGap <= MaxGap) begin
                            countD    = countQ + 4'd1;
                            lastLineD = vpixInQ;
                            if (countQ + 4'd1 == ConfirmLast) begin
                                stateD = StEmit;
                            end
                        end else begin
                            restart = 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (!fifoFullQ) begin
                        writeD = 1'b1;
                        stateD = StHold;
                    end
                end
                StHold: restart = newDataQ && (codeInQ != codeQ);
                default: stateD = StIdle;
            endcase
        end

        if (restart) begin
            stateD     = StTrack;
            codeD      = codeInQ;
            firstLineD = vpixInQ;
            lastLineD  = vpixInQ;
            countD     = 4'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ        <= StIdle;
            codeQ         <= '0;
            firstLineQ    <= '0;
            lastLineQ     <= '0;
            countQ        <= '0;
            oFifoWrEn     <= 1'b0;
            oFifoData     <= '0;
            oBusy         <= 1'b0;
            oConfirmCount <= '0;
            oDropCount    <= '0;
        end else begin
            stateQ     <= stateD;
            codeQ      <= codeD;
            firstLineQ <= firstLineD;
            lastLineQ  <= lastLineD;
            countQ     <= countD;
            oFifoWrEn  <= writeD;
            oBusy      <= (stateD != StIdle);
            if (writeD) begin
                oFifoData <= {firstLineQ, codeQ};
                if (oConfirmCount != 16'hFFFF) begin
                    oConfirmCount <= oConfirmCount + 16'd1;
                end
            end
            if (dropInc && oDropCount != 16'hFFFF) begin
                oDropCount <= oDropCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_scanner_result_arbiter.sv
// Scoreboard bench for scanner_result_arbiter: expected FIFO words are queued as stimulus is
// driven and compared whenever the DUT strobes oFifoWrEn.
module tb_scanner_result_arbiter;

    logic        iClk = 1'b0;
    logic        iRst, iEnable, iFrameStart, iNewData, iFifoFull;
    logic [51:0] iDataCode;
    logic [9:0]  iVpixel;
    logic        oFifoWrEn, oBusy;
    logic [61:0] oFifoData;
    logic [15:0] oConfirmCount, oDropCount, oBadCount;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [61:0] sb[$];

    scanner_result_arbiter dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iEnable       (iEnable),
        .iFrameStart   (iFrameStart),
        .iNewData      (iNewData),
        .iDataCode     (iDataCode),
        .iVpixel       (iVpixel),
        .iFifoFull     (iFifoFull),
        .oFifoWrEn     (oFifoWrEn),
        .oFifoData     (oFifoData),
        .oBusy         (oBusy),
        .oConfirmCount (oConfirmCount),
        .oDropCount    (oDropCount),
        .oBadCount     (oBadCount)
    );

    always #5 iClk = ~iClk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Digit 12 (rightmost) comes from the least significant decimal digit.
    function automatic logic [51:0] mkCode(input longint unsigned n);
        logic [51:0] c;
        longint unsigned v;
        v = n;
        c = '0;
        for (int i = 12; i >= 0; i--) begin
            c[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return c;
    endfunction

    always @(negedge iClk) begin
        if (!iRst && oFifoWrEn) begin
            if (sb.size() == 0) checkEq("unexpectedWrite", 64'd1, 64'd0);
            else checkEq("fifoData", {2'b0, oFifoData}, {2'b0, sb.pop_front()});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic resetDut();
        @(negedge iClk);
        iRst = 1'b1; iEnable = 1'b1; iFrameStart = 1'b0; iNewData = 1'b0;
        iFifoFull = 1'b0; iDataCode = '0; iVpixel = '0;
        sb.delete();
        idle(3);
        iRst = 1'b0;
    endtask

    task automatic sendData(input logic [51:0] c, input logic [9:0] v, input logic frame);
        @(negedge iClk);
        iNewData = 1'b1; iDataCode = c; iVpixel = v; iFrameStart = frame;
        @(negedge iClk);
        iNewData = 1'b0; iFrameStart = 1'b0;
    endtask

    task automatic pulseFrame();
        @(negedge iClk);
        iFrameStart = 1'b1;
        @(negedge iClk);
        iFrameStart = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        idle(6);
        checkEq(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [51:0] codeA, codeB, codeBad;
        codeA   = mkCode(64'd4006381333931);
        codeB   = mkCode(64'd5901234123457);
        codeBad = mkCode(64'd4006381333932);

        // Reset state
        resetDut();
        checkEq("rstWrEn", 64'(oFifoWrEn), 64'd0);
        checkEq("rstData", 64'(oFifoData), 64'd0);
        checkEq("rstBusy", 64'(oBusy), 64'd0);
        checkEq("rstConfirm", 64'(oConfirmCount), 64'd0);
        checkEq("rstDrop", 64'(oDropCount), 64'd0);
        checkEq("rstBad", 64'(oBadCount), 64'd0);

        // Basic confirmation with exact two-cycle latency
        for (int i = 0; i < 3; i++) sendData(codeA, 10'(100 + 2 * i), 1'b0);
        sb.push_back({10'd100, codeA});
        sendData(codeA, 10'd106, 1'b0);
        checkEq("t1LatE1", 64'(oFifoWrEn), 64'd0);
        @(negedge iClk);
        checkEq("t1LatE2", 64'(oFifoWrEn), 64'd0);
        checkEq("t1Busy", 64'(oBusy), 64'd1);
        @(negedge iClk);
        checkEq("t1LatE3", 64'(oFifoWrEn), 64'd1);
        @(negedge iClk);
        checkEq("t1OnePulse", 64'(oFifoWrEn), 64'd0);
        checkEq("t1Hold", 64'(oFifoData), 64'({10'd100, codeA}));
        drainCheck("t1Pending");
        checkEq("t1Confirm", 64'(oConfirmCount), 64'd1);

        // Extra decodes in the same frame do not repeat; a new frame allows another write
        resetDut();
        sb.push_back({10'd100, codeA});
        for (int i = 0; i < 7; i++) sendData(codeA, 10'(100 + 2 * i), 1'b0);
        drainCheck("t2Single");
        checkEq("t2Confirm1", 64'(oConfirmCount), 64'd1);
        pulseFrame();
        sb.push_back({10'd200, codeA});
        for (int i = 0; i < 4; i++) sendData(codeA, 10'(200 + 2 * i), 1'b0);
        drainCheck("t2Second");
        checkEq("t2Confirm2", 64'(oConfirmCount), 64'd2);

        // Gap larger than the limit restarts tracking
        resetDut();
        sb.push_back({10'd120, codeA});
        sendData(codeA, 10'd100, 1'b0);
        sendData(codeA, 10'd102, 1'b0);
        for (int i = 0; i < 4; i++) sendData(codeA, 10'(120 + 2 * i), 1'b0);
        drainCheck("t3Gap");

        // FIFO full through confirmation, then frame start drops the code
        resetDut();
        iFifoFull = 1'b1;
        for (int i = 0; i < 4; i++) sendData(codeA, 10'(100 + 2 * i), 1'b0);
        idle(4);
        checkEq("t4BusyFull", 64'(oBusy), 64'd1);
        pulseFrame();
        idle(2);
        checkEq("t4Drop", 64'(oDropCount), 64'd1);
        checkEq("t4NoConfirm", 64'(oConfirmCount), 64'd0);
        checkEq("t4Idle", 64'(oBusy), 64'd0);
        drainCheck("t4NoWrite");

        // FIFO released five cycles after confirmation
        for (int i = 0; i < 4; i++) sendData(codeA, 10'(300 + 2 * i), 1'b0);
        idle(5);
        checkEq("t4bStillFull", 64'(oFifoWrEn), 64'd0);
        sb.push_back({10'd300, codeA});
        iFifoFull = 1'b0;
        @(negedge iClk);
        checkEq("t4bRelE1", 64'(oFifoWrEn), 64'd0);
        @(negedge iClk);
        checkEq("t4bRelE2", 64'(oFifoWrEn), 64'd1);
        drainCheck("t4bPending");
        checkEq("t4bConfirm", 64'(oConfirmCount), 64'd1);
        checkEq("t4bDrop", 64'(oDropCount), 64'd1);

        // Alternating codes never confirm; frame start with a decode counts that decode
        resetDut();
        for (int i = 0; i < 8; i++) sendData((i % 2 == 0) ? codeA : codeB, 10'(400 + i), 1'b0);
        drainCheck("t5Alt");
        checkEq("t5NoConfirm", 64'(oConfirmCount), 64'd0);
        sb.push_back({10'd500, codeB});
        sendData(codeB, 10'd500, 1'b1);
        for (int i = 1; i < 4; i++) sendData(codeB, 10'(500 + 2 * i), 1'b0);
        drainCheck("t5FrameCoinc");
        checkEq("t5Confirm", 64'(oConfirmCount), 64'd1);

        // Bad checksum decodes
        resetDut();
`ifndef SCANNER_ARB_CHECKSUM_EN
        sb.push_back({10'd100, codeBad});
`endif
        for (int i = 0; i < 4; i++) sendData(codeBad, 10'(100 + 2 * i), 1'b0);
        drainCheck("t6Pending");
`ifdef SCANNER_ARB_CHECKSUM_EN
        checkEq("t6Bad", 64'(oBadCount), 64'd4);
        checkEq("t6Idle", 64'(oBusy), 64'd0);
        checkEq("t6Confirm", 64'(oConfirmCount), 64'd0);
`else
        checkEq("t6Bad", 64'(oBadCount), 64'd0);
        checkEq("t6Confirm", 64'(oConfirmCount), 64'd1);
`endif

        // Disabled: decodes ignored, no writes
        resetDut();
        iEnable = 1'b0;
        for (int i = 0; i < 4; i++) sendData(codeA, 10'(100 + 2 * i), 1'b0);
        drainCheck("t7Disabled");
        checkEq("t7Busy", 64'(oBusy), 64'd0);
        checkEq("t7Confirm", 64'(oConfirmCount), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
